pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-stage program-counter controller for the pipelined MIPS core. It owns the PC register and picks the next fetch address each cycle from reset, stall, branch/jump redirect, exception entry and ERET return. It tracks the branch-delay slot and flags illegal fetch addresses for CP0. It sits between the F-stage instruction memory, the D-stage branch/jump logic and CP0.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset
- EXC_VECTOR, 32'h0000_4180, exception/interrupt entry address
- IM_LO, 32'h0000_3000, lowest legal fetch address
- IM_HI, 32'h0000_6FFC, highest legal fetch address
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC (hazard unit)
- br_taken  in  1  D-stage branch resolved taken
- br_target  in  32  branch target
- jump  in  1  D-stage j/jal/jr/jalr
- jump_target  in  32  jump target
- exc_req  in  1  CP0 requests exception/interrupt entry
- eret  in  1  ERET in the commit stage
- epc  in  32  return address from CP0
- pc  out  32  current fetch address (registered)
- pc4  out  32  pc + 4
- f_bd  out  1  instruction at pc is a branch-delay slot
- f_adel  out  1  pc misaligned or outside [IM_LO, IM_HI]
- flush  out  1  one-cycle pulse: squash F/D/E/M pipeline registers

## Operation
- Next-PC priority, highest first: reset > exc_req > eret > stall > (jump | br_taken) > pc4.
- exc_req: pc <= EXC_VECTOR; flush <= 1; f_bd <= 0. This overrides stall.
- eret: pc <= epc; flush <= 1; f_bd <= 0. This overrides stall. If exc_req and eret are both high, exc_req wins.
- stall: pc, f_bd and the redirect state hold. flush <= 0.
- Redirect: when jump or br_taken is high with no stall, pc <= pc4 so the delay slot is fetched, and the target is latched into redirect_pc.
- If jump and br_taken are both high, jump_target wins.
- State machine:
  - SEQ: normal sequential fetch.
  - SLOT: delay slot is in F; f_bd = 1.
  - SLOT to SEQ on the first non-stalled cycle: pc <= redirect_pc.
  - exc_req or eret in either state: go to SEQ and discard redirect_pc.
- f_adel is combinational from the pc register: pc[1:0] != 0, or pc < IM_LO, or pc > IM_HI. It does not change sequencing; CP0 decides.
- Arithmetic:
  - pc4 is 32-bit unsigned and wraps modulo 2^32, with no carry out.
  - Targets are used as given, with no masking; misalignment surfaces only through f_adel.

## Timing
- Reset values: pc = RESET_PC, pc4 = RESET_PC+4, f_bd = 0, f_adel = 0, flush = 0, state = SEQ, redirect_pc = 0.
- Single-cycle latency: inputs sampled at edge N take effect on pc after edge N.
- flush is registered, so it is high for exactly the cycle in which pc shows the new vector or epc.
- Reset asserted mid-redirect (state SLOT) returns to SEQ at RESET_PC with no pending redirect.
- A new redirect request while in SLOT is ignored. The delay slot cannot be a branch, so this is architecturally illegal.
- pc = 32'hFFFF_FFFC gives pc4 = 0, and f_adel reports the out-of-range address.

## Structure
- Shared package `mips_defs`: RESET_PC, EXC_VECTOR, IM_LO, IM_HI, and the state encoding (SEQ = 1'b0, SLOT = 1'b1).
- One sub-module, `pc_inc`: a 32-bit combinational +4 incrementer, instantiated once for pc4.
- Everything else lives in a single always block for pc, state, redirect_pc and flush, plus continuous assigns for f_bd and f_adel.

## Test plan
- Reset, then 3 free cycles: pc = 3000, 3004, 3008, 300C; f_bd = 0; flush = 0.
- br_taken with br_target = 3100 at pc = 3008:
  - next pc = 300C with f_bd = 1
  - then pc = 3100 with f_bd = 0
  - a 2-cycle stall during SLOT holds pc = 300C and f_bd = 1.
- Simultaneous jump (jump_target = 3200) and br_taken (br_target = 3100): delay slot is fetched, then pc = 3200.
- exc_req while stall = 1 and state = SLOT: next pc = 4180, flush = 1 for one cycle, f_bd = 0, and the pending target is never fetched.
- eret with epc = 3010, then exc_req and eret both high: first pc = 3010 with flush pulse, then pc = 4180.
- Jump to 3002: f_adel = 1. Jump to 7000: f_adel = 1. Assert reset in the next cycle: pc = 3000 and f_adel = 0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-stage constants and the PC sequencer state encoding.
package mips_defs;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

    typedef enum logic {
        SEQ  = 1'b0,
        SLOT = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of redirect requests coming into, and fetch status going out of, the PC sequencer.
interface pc_sequencer_if;

    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        f_bd;
    logic        f_adel;
    logic        flush;

    modport master (
        output stall, br_taken, br_target, jump, jump_target, exc_req, eret, epc,
        input  pc, pc4, f_bd, f_adel, flush
    );

    modport slave (
        input  stall, br_taken, br_target, jump, jump_target, exc_req, eret, epc,
        output pc, pc4, f_bd, f_adel, flush
    );

endinterface

// File: rtl/pc_inc.sv
// 32-bit +4 incrementer; wraps modulo 2^32 with no carry out.
module pc_inc (
    input  logic [31:0] a,
    output logic [31:0] y
);

    assign y = a + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with delay-slot tracking, exception/ERET redirect and fetch-address check.
module pc_sequencer
    import mips_defs::*;
(
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);

    pc_state_t   state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] redirect_pc, redirect_pc_nxt;
    logic        flush_q, flush_nxt;
    logic [31:0] pc_plus4;

    pc_inc u_pc_inc (
        .a (pc_q),
        .y (pc_plus4)
    );

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        pc_nxt          = pc_plus4;
        state_nxt       = state;
        redirect_pc_nxt = redirect_pc;
        flush_nxt       = 1'b0;

        if (bus.exc_req) begin
            pc_nxt          = EXC_VECTOR;
            state_nxt       = SEQ;
            redirect_pc_nxt = '0;
            flush_nxt       = 1'b1;
        end else if (bus.eret) begin
            pc_nxt          = bus.epc;
            state_nxt       = SEQ;
            redirect_pc_nxt = '0;
            flush_nxt       = 1'b1;
        end else if (bus.stall) begin
            pc_nxt = pc_q;
        end else if (state == SLOT) begin
            // A redirect request here would come from the delay slot itself, which is illegal.
            pc_nxt    = redirect_pc;
            state_nxt = SEQ;
        end else if (bus.jump || bus.br_taken) begin
            state_nxt       = SLOT;
            redirect_pc_nxt = bus.jump ? bus.jump_target : bus.br_target;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            state       <= SEQ;
            redirect_pc <= '0;
            flush_q     <= 1'b0;
        end else begin
            pc_q        <= pc_nxt;
            state       <= state_nxt;
            redirect_pc <= redirect_pc_nxt;
            flush_q     <= flush_nxt;
        end
    end

    assign bus.pc     = pc_q;
    assign bus.pc4    = pc_plus4;
    assign bus.flush  = flush_q;
    assign bus.f_bd   = (state == SLOT);
    assign bus.f_adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: driver queues expected fetch state, monitor compares.
module tb_pc_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        bd;
        logic        adel;
        logic        flush;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    pc_sequencer_if sif ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then queue the state expected after the following edge.
    task automatic step(input logic rst, input logic stl,
                        input logic bt, input logic [31:0] bta,
                        input logic jmp, input logic [31:0] jta,
                        input logic exc, input logic er, input logic [31:0] ep,
                        input logic [31:0] e_pc, input logic e_bd,
                        input logic e_adel, input logic e_flush);
        exp_t e;
        @(negedge clk);
        reset           = rst;
        sif.stall       = stl;
        sif.br_taken    = bt;
        sif.br_target   = bta;
        sif.jump        = jmp;
        sif.jump_target = jta;
        sif.exc_req     = exc;
        sif.eret        = er;
        sif.epc         = ep;
        @(posedge clk);
        e.pc    = e_pc;
        e.pc4   = e_pc + 32'd4;
        e.bd    = e_bd;
        e.adel  = e_adel;
        e.flush = e_flush;
        exp_q.push_back(e);
    endtask

    task automatic free_cycle(input logic [31:0] e_pc, input logic e_bd, input logic e_adel);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, e_pc, e_bd, e_adel, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc",     sif.pc,     e.pc);
            check("pc4",    sif.pc4,    e.pc4);
            check("f_bd",   {31'b0, sif.f_bd},   {31'b0, e.bd});
            check("f_adel", {31'b0, sif.f_adel}, {31'b0, e.adel});
            check("flush",  {31'b0, sif.flush},  {31'b0, e.flush});
        end
    end

    initial begin
        reset           = 1'b1;
        sif.stall       = 1'b0;
        sif.br_taken    = 1'b0;
        sif.br_target   = '0;
        sif.jump        = 1'b0;
        sif.jump_target = '0;
        sif.exc_req     = 1'b0;
        sif.eret        = 1'b0;
        sif.epc         = '0;

        // Reset and free-running fetch
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0);
        free_cycle(32'h3004, 0, 0);
        free_cycle(32'h3008, 0, 0);

        // Taken branch at 3008 with a 2-cycle stall in the delay slot
        step(0, 0, 1, 32'h3100, 0, 0, 0, 0, 0, 32'h300C, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h300C, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h300C, 1, 0, 0);
        free_cycle(32'h3100, 0, 0);

        // Jump and branch together: jump target wins after the slot
        step(0, 0, 1, 32'h3100, 1, 32'h3200, 0, 0, 0, 32'h3104, 1, 0, 0);
        free_cycle(32'h3200, 0, 0);

        // Exception during a stalled slot discards the pending target
        step(0, 0, 1, 32'h3300, 0, 0, 0, 0, 0, 32'h3204, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h4180, 0, 0, 1);
        free_cycle(32'h4184, 0, 0);
        free_cycle(32'h4188, 0, 0);

        // Second redirect request while in the slot is ignored
        step(0, 0, 0, 0, 1, 32'h3400, 0, 0, 0, 32'h418C, 1, 0, 0);
        step(0, 0, 0, 0, 1, 32'h3500, 0, 0, 0, 32'h3400, 0, 0, 0);
        free_cycle(32'h3404, 0, 0);

        // ERET, then exc_req and eret together
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h3010, 32'h3010, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h3010, 32'h4180, 0, 0, 1);
        free_cycle(32'h4184, 0, 0);

        // ERET overrides stall
        step(0, 1, 0, 0, 0, 0, 0, 1, 32'h3020, 32'h3020, 0, 0, 1);

        // Upper bound of the legal window, then just past it
        step(0, 0, 0, 0, 1, 32'h6FFC, 0, 0, 0, 32'h3024, 1, 0, 0);
        free_cycle(32'h6FFC, 0, 0);
        free_cycle(32'h7000, 0, 1);

        // Misaligned jump target
        step(0, 0, 0, 0, 1, 32'h3002, 0, 0, 0, 32'h7004, 1, 1, 0);
        free_cycle(32'h3002, 0, 1);
        free_cycle(32'h3006, 0, 1);

        // Out-of-range jump target, then reset in the middle of a redirect
        step(0, 0, 0, 0, 1, 32'h7000, 0, 0, 0, 32'h300A, 1, 1, 0);
        free_cycle(32'h7000, 0, 1);
        step(0, 0, 0, 0, 1, 32'h3600, 0, 0, 0, 32'h7004, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0);
        free_cycle(32'h3004, 0, 0);

        // Wrap of pc4 at the top of the address space
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h3008, 1, 0, 0);
        free_cycle(32'hFFFF_FFFC, 0, 1);
        free_cycle(32'h0000_0000, 0, 1);

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
